// File: rtl/sample_memory.sv
// sample_memory: circular sample store for the IAGC datapath.
// The sampler appends words sequentially; the command parser reads them back
// by offset from the oldest stored sample. A hardware clean sequence zeroes
// the whole array one word per cycle and then empties the buffer.
module sample_memory #(
  parameter int DATA_SIZE   = 14,
  parameter int ADDR_SIZE   = 10,
  parameter int MEMORY_SIZE = 1024,
  parameter int OVERWRITE   = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_write,
  input  logic [DATA_SIZE-1:0] i_data,
  input  logic                 i_read,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic                 i_clean,
  output logic [DATA_SIZE-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_error,
  output logic [ADDR_SIZE:0]   o_count,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_busy,
  output logic                 o_overflow
);

  // Pointer and count constants sized to their registers.
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEMORY_SIZE - 1);
  localparam logic [ADDR_SIZE-1:0] ONE_ADDR  = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE:0]   MEM_CNT   = (ADDR_SIZE + 1)'(MEMORY_SIZE);
  localparam logic [ADDR_SIZE:0]   ONE_CNT   = (ADDR_SIZE + 1)'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAN = 1'b1
  } state_t;

  state_t               state;
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] base;
  logic [ADDR_SIZE:0]   count;
  logic [ADDR_SIZE-1:0] clean_addr;

  // Sample storage; contents are deliberately not reset.
  logic [DATA_SIZE-1:0] mem [0:MEMORY_SIZE-1];

  // Single write port shared by sampler writes and the clean sequence.
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [DATA_SIZE-1:0] mem_wdata;

  logic [ADDR_SIZE-1:0] wr_ptr_inc;
  logic [ADDR_SIZE-1:0] base_inc;
  logic [ADDR_SIZE-1:0] clean_inc;
  logic [ADDR_SIZE:0]   rd_sum;
  logic [ADDR_SIZE:0]   rd_wrapped;
  logic [ADDR_SIZE-1:0] rd_index;
  logic                 rd_ok;
  logic                 is_full;

  assign is_full    = (count == MEM_CNT);
  assign o_count    = count;
  assign o_empty    = (count == '0);
  assign o_full     = is_full;
  assign o_busy     = (state == CLEAN);

  // Wrapping pointer increments and the divider-free read address:
  // base + offset never exceeds 2*MEMORY_SIZE-2 for a valid offset, so a
  // single conditional subtraction implements the modulo.
  always_comb begin
    wr_ptr_inc = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ONE_ADDR;
    base_inc   = (base == LAST_ADDR) ? '0 : base + ONE_ADDR;
    clean_inc  = (clean_addr == LAST_ADDR) ? '0 : clean_addr + ONE_ADDR;
    rd_sum     = {1'b0, base} + {1'b0, i_addr};
    rd_wrapped = (rd_sum >= MEM_CNT) ? (rd_sum - MEM_CNT) : rd_sum;
    rd_index   = rd_wrapped[ADDR_SIZE-1:0];
    rd_ok      = ({1'b0, i_addr} < count);
  end

  // Select what (if anything) is written to the array this cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr;
    mem_wdata = i_data;
    if (state == CLEAN) begin
      mem_we    = 1'b1;
      mem_waddr = clean_addr;
      mem_wdata = '0;
    end else if (!i_clean && i_write && (!is_full || (OVERWRITE != 0))) begin
      mem_we = 1'b1;
    end
  end

  // Array write port; reads elsewhere see the pre-write contents.
  always_ff @(posedge i_clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM, pointers, occupancy and registered read/status outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      base       <= '0;
      count      <= '0;
      clean_addr <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_error    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_error <= 1'b0;
      case (state)
        IDLE: begin
          if (i_clean) begin
            // Clean wins; a read issued alongside it is rejected.
            state      <= CLEAN;
            clean_addr <= '0;
            if (i_read) begin
              o_error <= 1'b1;
            end
          end else begin
            // Read uses pre-write base/count, so a same-cycle overwrite
            // does not shift the sample it returns.
            if (i_read) begin
              if (rd_ok) begin
                o_data  <= mem[rd_index];
                o_valid <= 1'b1;
              end else begin
                o_error <= 1'b1;
              end
            end
            if (i_write) begin
              if (!is_full) begin
                wr_ptr <= wr_ptr_inc;
                count  <= count + ONE_CNT;
              end else begin
                o_overflow <= 1'b1;
                if (OVERWRITE != 0) begin
                  wr_ptr <= wr_ptr_inc;
                  base   <= base_inc;
                end
              end
            end
          end
        end
        CLEAN: begin
          clean_addr <= clean_inc;
          if (i_read) begin
            o_error <= 1'b1;
          end
          if (clean_addr == LAST_ADDR) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            base       <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_memory.sv
// Directed bench for sample_memory: two instances (drop-when-full and
// overwrite-oldest) share one stimulus stream and are checked separately.
module tb_sample_memory;

  localparam int DW = 14;
  localparam int AW = 3;
  localparam int MS = 8;

  logic          clk;
  logic          rst_n;
  logic          wr;
  logic [DW-1:0] wdata;
  logic          rd;
  logic [AW-1:0] raddr;
  logic          cln;

  logic [DW-1:0] d0_data,  d1_data;
  logic          d0_valid, d1_valid;
  logic          d0_error, d1_error;
  logic [AW:0]   d0_count, d1_count;
  logic          d0_empty, d1_empty;
  logic          d0_full,  d1_full;
  logic          d0_busy,  d1_busy;
  logic          d0_ovf,   d1_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int busy0_cycles;
  int busy1_cycles;

  sample_memory #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .MEMORY_SIZE(MS), .OVERWRITE(0)) dut0 (
    .i_clock(clk), .i_reset_n(rst_n), .i_write(wr), .i_data(wdata),
    .i_read(rd), .i_addr(raddr), .i_clean(cln),
    .o_data(d0_data), .o_valid(d0_valid), .o_error(d0_error), .o_count(d0_count),
    .o_empty(d0_empty), .o_full(d0_full), .o_busy(d0_busy), .o_overflow(d0_ovf)
  );

  sample_memory #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .MEMORY_SIZE(MS), .OVERWRITE(1)) dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_write(wr), .i_data(wdata),
    .i_read(rd), .i_addr(raddr), .i_clean(cln),
    .o_data(d1_data), .o_valid(d1_valid), .o_error(d1_error), .o_count(d1_count),
    .o_empty(d1_empty), .o_full(d1_full), .o_busy(d1_busy), .o_overflow(d1_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("check %-24s observed %h expected %h ok", tag, obs, exp);
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr = 1'b0; rd = 1'b0; cln = 1'b0; wdata = '0; raddr = '0;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    wr = 1'b1; wdata = d;
    step();
    idle_inputs();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    rd = 1'b1; raddr = a;
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #23;
    // Reset state
    chk("rst count",    32'(d0_count), 32'd0);
    chk("rst empty",    32'(d0_empty), 32'd1);
    chk("rst full",     32'(d0_full),  32'd0);
    chk("rst busy",     32'(d0_busy),  32'd0);
    chk("rst overflow", 32'(d0_ovf),   32'd0);
    chk("rst valid",    32'(d0_valid), 32'd0);
    chk("rst error",    32'(d0_error), 32'd0);
    chk("rst data",     32'(d0_data),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Read of empty buffer
    do_read(3'd0);
    chk("empty rd error", 32'(d0_error), 32'd1);
    chk("empty rd valid", 32'(d0_valid), 32'd0);
    chk("empty count",    32'(d0_count), 32'd0);
    chk("empty empty",    32'(d0_empty), 32'd1);
    step();
    chk("error one pulse", 32'(d0_error), 32'd0);

    // Five writes then offsets 0..5
    for (int i = 0; i < 5; i++) do_write(DW'(14'h101 + i));
    chk("count 5", 32'(d0_count), 32'd5);
    chk("not empty", 32'(d0_empty), 32'd0);
    for (int i = 0; i < 5; i++) begin
      do_read(AW'(i));
      chk($sformatf("rd%0d data", i),  32'(d0_data),  32'h101 + 32'(i));
      chk($sformatf("rd%0d valid", i), 32'(d0_valid), 32'd1);
      chk($sformatf("rd%0d error", i), 32'(d0_error), 32'd0);
    end
    chk("ow1 rd4 data", 32'(d1_data), 32'h105);
    do_read(3'd5);
    chk("rd5 error", 32'(d0_error), 32'd1);
    chk("rd5 valid", 32'(d0_valid), 32'd0);
    chk("rd5 data holds", 32'(d0_data), 32'h105);
    step();
    chk("valid one pulse", 32'(d0_valid), 32'd0);

    // Fill past full
    rst_n = 1'b0; #2; rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) do_write(DW'(i));
    chk("ow0 full at 8", 32'(d0_full), 32'd1);
    chk("ow0 no ovf at 8", 32'(d0_ovf), 32'd0);
    do_write(14'h009);
    do_write(14'h00A);
    chk("ow0 count", 32'(d0_count), 32'd8);
    chk("ow0 full",  32'(d0_full),  32'd1);
    chk("ow0 ovf",   32'(d0_ovf),   32'd1);
    chk("ow1 count", 32'(d1_count), 32'd8);
    chk("ow1 ovf",   32'(d1_ovf),   32'd1);
    do_read(3'd7);
    chk("ow0 rd7", 32'(d0_data), 32'h008);
    chk("ow1 rd7 wrap", 32'(d1_data), 32'h00A);
    do_read(3'd0);
    chk("ow0 rd0", 32'(d0_data), 32'h001);
    chk("ow1 rd0", 32'(d1_data), 32'h003);

    // Same-cycle read offset 0 and write while full
    rd = 1'b1; raddr = 3'd0; wr = 1'b1; wdata = 14'h00B;
    step();
    idle_inputs();
    chk("rw ow1 pre-write", 32'(d1_data),  32'h003);
    chk("rw ow1 valid",     32'(d1_valid), 32'd1);
    chk("rw ow0 pre-write", 32'(d0_data),  32'h001);
    do_read(3'd0);
    chk("rw ow1 next",  32'(d1_data), 32'h004);
    chk("rw ow0 next",  32'(d0_data), 32'h001);
    do_read(3'd7);
    chk("rw ow1 newest", 32'(d1_data), 32'h00B);

    // Three writes then clean
    for (int i = 0; i < 3; i++) do_write(DW'(14'h00C + i));
    chk("pre-clean ovf", 32'(d0_ovf), 32'd1);
    busy0_cycles = 0;
    busy1_cycles = 0;
    cln = 1'b1;
    step();
    idle_inputs();
    if (d0_busy) busy0_cycles++;
    if (d1_busy) busy1_cycles++;
    rd = 1'b1; raddr = 3'd0;
    step();
    idle_inputs();
    chk("clean rd error", 32'(d0_error), 32'd1);
    chk("clean rd valid", 32'(d0_valid), 32'd0);
    if (d0_busy) busy0_cycles++;
    if (d1_busy) busy1_cycles++;
    wr = 1'b1; wdata = 14'h777;
    step();
    idle_inputs();
    if (d0_busy) busy0_cycles++;
    if (d1_busy) busy1_cycles++;
    for (int i = 0; i < 20 && (d0_busy || d1_busy); i++) begin
      step();
      if (d0_busy) busy0_cycles++;
      if (d1_busy) busy1_cycles++;
    end
    chk("ow0 busy cycles", 32'(busy0_cycles), 32'd8);
    chk("ow1 busy cycles", 32'(busy1_cycles), 32'd8);
    chk("post-clean count", 32'(d0_count), 32'd0);
    chk("post-clean empty", 32'(d0_empty), 32'd1);
    chk("post-clean ovf0",  32'(d0_ovf),   32'd0);
    chk("post-clean ovf1",  32'(d1_ovf),   32'd0);
    chk("post-clean full",  32'(d1_full),  32'd0);
    do_write(14'h3FFF);
    chk("post-clean count1", 32'(d1_count), 32'd1);
    do_read(3'd0);
    chk("post-clean rd0", 32'(d0_data), 32'h3FFF);
    chk("post-clean rd0 ow1", 32'(d1_data), 32'h3FFF);
    do_read(3'd1);
    chk("clean write ignored", 32'(d0_error), 32'd1);

    // Clean with a read in the same cycle, then reset 3 cycles in
    cln = 1'b1; rd = 1'b1; raddr = 3'd0;
    step();
    idle_inputs();
    chk("clean+rd error", 32'(d0_error), 32'd1);
    chk("clean+rd valid", 32'(d0_valid), 32'd0);
    step();
    step();
    chk("mid-clean busy", 32'(d0_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy0", 32'(d0_busy), 32'd0);
    chk("abort busy1", 32'(d1_busy), 32'd0);
    chk("abort count", 32'(d0_count), 32'd0);
    chk("abort empty", 32'(d1_empty), 32'd1);
    #1 rst_n = 1'b1;
    do_write(14'h055);
    do_write(14'h066);
    chk("after abort count", 32'(d0_count), 32'd2);
    do_read(3'd1);
    chk("after abort rd1", 32'(d0_data), 32'h066);
    do_read(3'd0);
    chk("after abort rd0", 32'(d1_data), 32'h055);
    chk("after abort busy", 32'(d0_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
